io_output_arbiter: RTL and testbench
====================================

Name: io_output_arbiter

Overview:
- Round-robin arbiter that shares the single UART byte-output controller between N requesters (e.g. CPU MMIO store path, debug monitor, boot-status reporter).
- Accepts one byte per grant from a requester and issues a one-cycle io_output_trigger to the output controller.
- Tracks the controller's io_output_ready_trigger through acceptance and completion before issuing the next byte.
- Sits between requesters and the output controller; drives that controller's io_output_value / io_output_trigger directly.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- TIMEOUT_CYCLES, 1048575, watchdog limit in clk cycles per wait state; used only with IO_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  requester i has a byte pending; held until its ack or withdrawn.
- req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
- req_ack  output  N_REQ  one-cycle pulse: byte of requester i captured.
- io_output_value  output  8  byte to the output controller; stable from trigger until the next grant.
- io_output_trigger  output  1  one-cycle start pulse to the output controller.
- io_output_ready_trigger  input  1  controller idle/ready; 1 = waiting for a byte.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  max(1,$clog2(N_REQ))  index of the last granted requester.
- timeout_err  output  1  sticky watchdog flag; tied 0 without the macro.

Behaviour:
- Reset (async assert, sync-release semantics not required): state IDLE; io_output_trigger 0; req_ack 0; io_output_value 0; grant_id 0; rr_ptr 0; busy 0; timeout_err 0.
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
- IDLE:
  - Grant only if io_output_ready_trigger==1 and |req_valid.
  - Winner is the first set req_valid index searching rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - On the granting edge, register: io_output_value <= winner's byte; grant_id <= winner; req_ack[winner] <= 1; io_output_trigger <= 1; go to ISSUE.
- ISSUE (exactly 1 cycle): trigger and ack are high. Next edge: both <= 0; go to WAIT_ACCEPT; req_valid is ignored.
- WAIT_ACCEPT: stay until io_output_ready_trigger==0, then go to WAIT_DONE.
- WAIT_DONE: stay until io_output_ready_trigger==1, then go to IDLE; rr_ptr <= (grant_id+1) mod N_REQ.
- Latency: valid sampled high in IDLE at edge k -> trigger and ack high during cycle k+1. Next grant is possible no earlier than the edge after ready returns to 1.
- At most one req_ack bit is high in any cycle. Ack never pulses for a requester whose valid was low at the grant edge.
- Requester may drop valid before ack (withdraw): no ack is issued and no byte is sent.
- Requester may drop valid, or present a new byte, in the cycle after ack.
- Ready low in IDLE (controller still busy, e.g. after reset mid-byte): no grant; wait for ready high.
- N_REQ==1: rr_ptr is constant 0; behaviour is otherwise identical.
- Reset mid-transfer: returns to IDLE immediately; the byte in flight at the controller is not re-sent and is not re-acked.

Optional Feature:
- Macro: IO_ARB_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to WAIT_ACCEPT and on entry to WAIT_DONE, and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES before the exit condition holds: go to IDLE, advance rr_ptr as on normal completion, set timeout_err=1 (sticky until rst_n).
- Without it: no counter; wait states wait indefinitely; timeout_err constant 0.

Test Plan:
- Single request: req_valid=4'b0001, data 8'h41, controller model drops ready 1 cycle after trigger and raises it 20 cycles later -> one trigger pulse with io_output_value=8'h41; req_ack=4'b0001 for 1 cycle, coincident with trigger; busy high for 22 cycles.
- Round robin: all four valid continuously, data 8'h10+i -> trigger sequence 10,11,12,13,10; grant_id 0,1,2,3,0; exactly one ack per byte.
- Ready low at idle: hold ready=0 while req_valid=4'b0100 -> no trigger. Raise ready -> trigger on the 2nd cycle after the raise edge, value equals req 2 data.
- Withdraw: req 1 valid for 1 cycle while ready=0, then dropped -> no ack, no trigger. Then req 3 valid -> granted, grant_id=3.
- Reset mid-transfer: assert rst_n=0 in WAIT_DONE -> trigger/ack 0 immediately, busy 0. After release with ready=0, no grant until ready=1.
- With IO_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: controller never drops ready after trigger -> return to IDLE after 16 cycles in WAIT_ACCEPT, timeout_err=1 stays set; next requester is granted. Without the macro, the arbiter stays busy and timeout_err stays 0.

Source files
------------

// File: rtl/io_output_arbiter.sv
// Round-robin share of one UART byte-output controller: grant edge -> trigger/ack next cycle, next grant after ready falls and rises again.
// Optional per-wait-state watchdog with sticky timeout_err: define IO_ARB_TIMEOUT_EN.
module io_output_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1048575,
  localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         io_output_value,
  output logic               io_output_trigger,
  input  logic               io_output_ready_trigger,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ISSUE       = 2'd1,
    S_WAIT_ACCEPT = 2'd2,
    S_WAIT_DONE   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_rr_ptr, r_grant_id, w_winner, w_hi_id, w_lo_id, w_next_ptr;
  logic [7:0]    r_value, w_win_dat, w_hi_dat, w_lo_dat;
  logic          w_hi_found, w_grant, w_advance, w_tmo;

  if (N_REQ < 1 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("io_output_arbiter: N_REQ must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  // Descending scan leaves the lowest valid index at or above rr_ptr (hi) and the lowest overall (lo, the wrap case).
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_hi_dat   = '0;
    w_lo_id    = '0;
    w_lo_dat   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_id  = GW'(i);
        w_lo_dat = req_data[8*i +: 8];
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_id    = GW'(i);
          w_hi_dat   = req_data[8*i +: 8];
        end
      end
    end
  end

  assign w_winner   = w_hi_found ? w_hi_id  : w_lo_id;
  assign w_win_dat  = w_hi_found ? w_hi_dat : w_lo_dat;
  assign w_grant    = (r_state == S_IDLE) && io_output_ready_trigger && (|req_valid);
  assign w_next_ptr = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:        if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE:       w_state_nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (!io_output_ready_trigger) w_state_nxt = S_WAIT_DONE;
        else if (w_tmo)               w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE:   if (io_output_ready_trigger || w_tmo) w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy              = (r_state != S_IDLE);
    io_output_trigger = (r_state == S_ISSUE);
    req_ack           = '0;
    if (r_state == S_ISSUE) req_ack[r_grant_id] = 1'b1;
    w_advance = ((r_state == S_WAIT_ACCEPT) && io_output_ready_trigger && w_tmo) ||
                ((r_state == S_WAIT_DONE) && (io_output_ready_trigger || w_tmo));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_value    <= w_win_dat;
        r_grant_id <= w_winner;
      end
      if (w_advance) r_rr_ptr <= w_next_ptr;
    end
  end

  assign io_output_value = r_value;
  assign grant_id        = r_grant_id;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_tmo_err, w_in_wait, w_tmo_hit;

  assign w_in_wait = (r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE);
  // Count is zero on the first cycle of a wait state, so TIMEOUT_CYCLES cycles elapse before the forced exit.
  assign w_tmo     = w_in_wait && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_hit = w_tmo && (((r_state == S_WAIT_ACCEPT) && io_output_ready_trigger) ||
                               ((r_state == S_WAIT_DONE) && !io_output_ready_trigger));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state != w_state_nxt) r_tmo_cnt <= '0;
      else if (w_in_wait)         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_hit) r_tmo_err <= 1'b1;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_output_arbiter.sv
// Directed bench for io_output_arbiter (N_REQ=4, TIMEOUT_CYCLES=16); inputs driven and outputs sampled 1ns after posedge.
module tb_io_output_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  io_output_value;
  logic        io_output_trigger;
  logic        io_output_ready_trigger;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  io_output_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .req_valid               (req_valid),
    .req_data                (req_data),
    .req_ack                 (req_ack),
    .io_output_value         (io_output_value),
    .io_output_trigger       (io_output_trigger),
    .io_output_ready_trigger (io_output_ready_trigger),
    .busy                    (busy),
    .grant_id                (grant_id),
    .timeout_err             (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_trig(input string tag);
    int n = 0;
    while (io_output_trigger !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_trig"}, 32'(io_output_trigger), 32'd1);
  endtask

  // Called in the ISSUE cycle; plays a controller that accepts and finishes within a few cycles.
  task automatic finish_xfer(input string tag);
    tick();
    chk({tag, "_ack_clr"}, 32'(req_ack), 32'd0);
    chk({tag, "_trig_clr"}, 32'(io_output_trigger), 32'd0);
    io_output_ready_trigger = 1'b0;
    tick();
    tick();
    io_output_ready_trigger = 1'b1;
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int trig_cnt;
    int ack_cnt;
    logic [1:0] exp_id [5];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;

    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    io_output_ready_trigger = 1'b1;
    tick();
    tick();
    chk("rst_trig", 32'(io_output_trigger), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_value", 32'(io_output_value), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Single request
    req_valid = 4'b0001;
    req_data  = 32'h0000_0041;
    tick();
    chk("single_trig", 32'(io_output_trigger), 32'd1);
    chk("single_ack", 32'(req_ack), 32'h1);
    chk("single_value", 32'(io_output_value), 32'h41);
    chk("single_grant", 32'(grant_id), 32'd0);
    busy_cnt = 32'(busy);
    trig_cnt = 32'(io_output_trigger);
    req_valid = 4'b0000;
    tick();
    chk("single_trig_1cyc", 32'(io_output_trigger), 32'd0);
    busy_cnt += 32'(busy);
    trig_cnt += 32'(io_output_trigger);
    io_output_ready_trigger = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_cnt += 32'(busy);
      trig_cnt += 32'(io_output_trigger);
    end
    io_output_ready_trigger = 1'b1;
    tick();
    chk("single_busy_cycles", busy_cnt, 32'd22);
    chk("single_trig_count", trig_cnt, 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Round robin with all requesters continuously valid
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      wait_trig("rr");
      chk("rr_value", 32'(io_output_value), 32'h10 + 32'(exp_id[k]));
      chk("rr_grant", 32'(grant_id), 32'(exp_id[k]));
      chk("rr_ack", 32'(req_ack), 32'd1 << exp_id[k]);
      finish_xfer("rr");
    end
    req_valid = 4'b0000;

    // Ready low in IDLE blocks the grant
    rst_n = 1'b0;
    io_output_ready_trigger = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h0077_0000;
    trig_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      trig_cnt += 32'(io_output_trigger);
    end
    chk("rdylow_no_trig", trig_cnt, 32'd0);
    chk("rdylow_busy", 32'(busy), 32'd0);
    io_output_ready_trigger = 1'b1;
    tick();
    chk("rdyhi_trig", 32'(io_output_trigger), 32'd1);
    chk("rdyhi_value", 32'(io_output_value), 32'h77);
    chk("rdyhi_grant", 32'(grant_id), 32'd2);
    chk("rdyhi_ack", 32'(req_ack), 32'h4);
    req_valid = 4'b0000;
    finish_xfer("rdyhi");

    // Withdraw before grant, then a different requester
    io_output_ready_trigger = 1'b0;
    req_valid = 4'b0010;
    req_data  = 32'h0000_9900;
    tick();
    chk("wd_ack", 32'(req_ack), 32'd0);
    chk("wd_trig", 32'(io_output_trigger), 32'd0);
    req_valid = 4'b0000;
    io_output_ready_trigger = 1'b1;
    trig_cnt = 0;
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      trig_cnt += 32'(io_output_trigger);
      ack_cnt  += 32'(req_ack != 4'b0000);
    end
    chk("wd_no_trig", trig_cnt, 32'd0);
    chk("wd_no_ack", ack_cnt, 32'd0);
    req_valid = 4'b1000;
    req_data  = 32'h5A00_0000;
    tick();
    chk("wd_r3_trig", 32'(io_output_trigger), 32'd1);
    chk("wd_r3_grant", 32'(grant_id), 32'd3);
    chk("wd_r3_value", 32'(io_output_value), 32'h5A);
    chk("wd_r3_ack", 32'(req_ack), 32'h8);

    // Reset while in WAIT_DONE
    req_valid = 4'b0000;
    tick();
    io_output_ready_trigger = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_trig", 32'(io_output_trigger), 32'd0);
    chk("mid_ack", 32'(req_ack), 32'd0);
    chk("mid_grant", 32'(grant_id), 32'd0);
    chk("mid_value", 32'(io_output_value), 32'd0);
    tick();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0041;
    rst_n = 1'b1;
    trig_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      trig_cnt += 32'(io_output_trigger);
    end
    chk("mid_no_grant", trig_cnt, 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);
    io_output_ready_trigger = 1'b1;
    tick();
    chk("mid_regrant_trig", 32'(io_output_trigger), 32'd1);
    chk("mid_regrant_value", 32'(io_output_value), 32'h41);
    req_valid = 4'b0000;
    finish_xfer("mid");

    // Controller never accepts: watchdog behaviour
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0033;
    wait_trig("tmo");
    req_valid = 4'b0000;
    for (int i = 0; i < 20; i++) tick();
`ifdef IO_ARB_TIMEOUT_EN
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    req_valid = 4'b0010;
    req_data  = 32'h0000_4400;
    wait_trig("tmo_next");
    chk("tmo_next_grant", 32'(grant_id), 32'd1);
    chk("tmo_next_value", 32'(io_output_value), 32'h44);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
    req_valid = 4'b0000;
`else
    chk("tmo_busy", 32'(busy), 32'd1);
    chk("tmo_err", 32'(timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
